// File: rtl/ipg_tx_insert_if.sv
// Bundles the reply-chunk push port, the TX block input stream and the
// post-insertion TX stream of ipg_tx_insert.
interface ipg_tx_insert_if #(
    parameter int ADDR_W = 3
);
    logic [63:0]     memq_chunk;
    logic            memq_write;
    logic [63:0]     tx_in_data;
    logic [1:0]      tx_in_hdr;
    logic            tx_in_valid;
    logic [63:0]     tx_out_data;
    logic [1:0]      tx_out_hdr;
    logic            tx_out_valid;
    logic            memq_full;
    logic [ADDR_W:0] memq_count;
    logic            overflow;
    logic            inserted;

    modport master (
        output memq_chunk, memq_write, tx_in_data, tx_in_hdr, tx_in_valid,
        input  tx_out_data, tx_out_hdr, tx_out_valid, memq_full, memq_count,
               overflow, inserted
    );

    modport slave (
        input  memq_chunk, memq_write, tx_in_data, tx_in_hdr, tx_in_valid,
        output tx_out_data, tx_out_hdr, tx_out_valid, memq_full, memq_count,
               overflow, inserted
    );
endinterface

// File: rtl/ipg_tx_insert.sv
// Replaces idle blocks in the inter-packet gap of an encoded TX stream with
// queued IPG reply chunks, one chunk per idle, in FIFO order.
module ipg_tx_insert #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          reset,
    ipg_tx_insert_if.slave bus
);
    typedef enum logic [1:0] {FRAME, GAP, OPEN} frame_state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    frame_state_t      state, state_nxt;

    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic        out_valid, out_inserted, out_overflow;

    logic [7:0] bt;
    logic       is_ctrl, is_idle, is_start, is_term, full, do_pop, do_push, drop;

    always_comb begin
        bt       = bus.tx_in_data[7:0];
        is_ctrl  = (bus.tx_in_hdr == 2'b10);
        is_idle  = is_ctrl && (bt == 8'h1e) && (bus.tx_in_data[63:8] == '0);
        is_start = is_ctrl && (bt == 8'h33 || bt == 8'h78);
        is_term  = is_ctrl && (bt == 8'h87 || bt == 8'h99 || bt == 8'haa || bt == 8'hb4 ||
                               bt == 8'hcc || bt == 8'hd2 || bt == 8'he1 || bt == 8'hff);
        full     = (count == FULL_COUNT);
        // An empty FIFO never pops, so a same-cycle push can never be bypassed out.
        do_pop   = bus.tx_in_valid && is_idle && (state == OPEN) && (count != '0);
        // A pop in the same cycle frees a slot, so a push while full still lands.
        do_push  = bus.memq_write && (!full || do_pop);
        drop     = bus.memq_write && full && !do_pop;
    end

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (bus.tx_in_valid) begin
            if (is_start)                         state_nxt = FRAME;
            else if (state == FRAME && is_term)   state_nxt = GAP;
            else if (state != FRAME && is_idle)   state_nxt = OPEN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= GAP;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_data     <= '0;
            out_hdr      <= '0;
            out_valid    <= 1'b0;
            out_inserted <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            out_overflow <= drop;
            out_valid    <= bus.tx_in_valid;
            out_inserted <= do_pop;

            if (bus.tx_in_valid) begin
                out_data <= do_pop ? mem[rd_ptr] : bus.tx_in_data;
                out_hdr  <= do_pop ? 2'b10       : bus.tx_in_hdr;
            end

            if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);

            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the chunk storage has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= bus.memq_chunk;
    end

    assign bus.tx_out_data  = out_data;
    assign bus.tx_out_hdr   = out_hdr;
    assign bus.tx_out_valid = out_valid;
    assign bus.inserted     = out_inserted;
    assign bus.overflow     = out_overflow;
    assign bus.memq_count   = count;
    assign bus.memq_full    = full;
endmodule

// File: doc/ipg_tx_insert.md
IPG_TX_INSERT -- requirements
Module: ipg_tx_insert

Interface
REQ-001 Parameter DEPTH, default 8, sets the reply-chunk FIFO depth in entries (power of two).
REQ-002 Parameter ADDR_W, default 3, is the FIFO pointer width and equals log2(DEPTH).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memq_chunk  input  64  reply chunk from the IPG processor; bits [7:0] already carry BT 0x1f.
REQ-006 memq_write  input  1  push memq_chunk into the FIFO this cycle.
REQ-007 tx_in_data  input  64  encoded TX block payload; bits [7:0] are the block type for control blocks.
REQ-008 tx_in_hdr  input  2  sync header: 2'b01 = data, 2'b10 = control.
REQ-009 tx_in_valid  input  1  tx_in_data/tx_in_hdr valid this cycle.
REQ-010 tx_out_data  output  64  TX block payload after insertion.
REQ-011 tx_out_hdr  output  2  TX sync header after insertion.
REQ-012 tx_out_valid  output  1  tx_out_data/tx_out_hdr valid.
REQ-013 memq_full  output  1  FIFO holds DEPTH entries.
REQ-014 memq_count  output  ADDR_W+1  number of entries in the FIFO.
REQ-015 overflow  output  1  one-cycle pulse when a push is dropped.
REQ-016 inserted  output  1  one-cycle pulse, aligned with tx_out_valid, when the output block is a replaced chunk.

Function
REQ-017 An idle block is tx_in_hdr=2'b10, tx_in_data[7:0]=0x1e, and tx_in_data[63:8]=0.
REQ-018 The frame tracker SHALL have three states: FRAME, GAP and OPEN, and SHALL advance only on tx_in_valid.
- Any state -> FRAME on a control block with BT 0x33 or 0x78.
- FRAME -> GAP on a terminate BT (0x87, 0x99, 0xaa, 0xb4, 0xcc, 0xd2, 0xe1, 0xff).
- GAP -> OPEN on an idle block.
- OPEN remains OPEN on an idle block.
- Any other block leaves the state unchanged.
REQ-019 Replacement SHALL occur only when all of the following hold: tx_in_valid, the block is idle, the tracker state is OPEN (evaluated before this block's transition), and memq_count > 0.
REQ-020 On replacement, the block SHALL output the FIFO head as tx_out_data, set tx_out_hdr=2'b10, pop exactly one entry, and pulse inserted.
REQ-021 On non-replacement, tx_in_data and tx_in_hdr SHALL pass through unchanged.
REQ-022 Latency is exactly one cycle from tx_in_* to tx_out_*; tx_out_valid is tx_in_valid delayed by one cycle.
REQ-023 Outputs are registered, and output registers hold their values when tx_in_valid=0.
REQ-024 On a push while not full, memq_chunk is written at the write pointer and memq_count increments.
REQ-025 On a push while full, the chunk is dropped, overflow pulses, and the FIFO is unchanged.
REQ-026 On a push and pop in the same cycle, both complete and memq_count is unchanged; this holds even when full, because the pop frees the slot.
REQ-027 On a pop and push in the same cycle while empty, no pop occurs (REQ-019), the push is stored, and the popped data is never the same-cycle push.
REQ-028 Pointers are ADDR_W bits, wrap modulo DEPTH, and chunks leave in FIFO order.
REQ-029 Chunks from one reply SHALL never be reordered, but may be separated by frames.
REQ-030 The tracker state after reset is GAP, so at least one idle block passes before the first insertion.

Reset
REQ-031 While reset=1:
- tx_out_data=0, tx_out_hdr=0, tx_out_valid=0, inserted=0, overflow=0.
- memq_count=0, memq_full=0.
- Both FIFO pointers=0 and the tracker state is GAP.
REQ-032 A reset asserted mid-operation SHALL discard all queued chunks and a partially replaced stream; outputs resume on the first tx_in_valid after reset deasserts.

Verification
REQ-033 Push chunk 0xAAAA_..._AA1F, then feed 3 idle blocks -> output 1 is idle, output 2 is 0xAAAA_..._AA1F with hdr 2'b10 and inserted=1, output 3 is idle, and memq_count=0.
REQ-034 Queue 2 chunks; feed start 0x78, 4 data blocks, terminate 0x87, then 3 idles -> the frame and the first idle pass unchanged, and chunks 1 and 2 replace idles 2 and 3 in order.
REQ-035 Push 9 chunks with no idles -> memq_full=1 after the 8th push, overflow pulses once on the 9th, and memq_count=8.
REQ-036 With the FIFO full, push and idle-replace in the same cycle while OPEN -> memq_count stays 8, overflow=0, and the oldest chunk is output.
REQ-037 Push 8 chunks, drain 8, push 8, drain 8 -> 16 chunks emerge in push order, proving pointer wrap.
REQ-038 Assert reset with 3 chunks queued -> outputs go to 0 asynchronously; after release, 2 idles pass unchanged with no insertion.
